// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: one SLICE-bit chunk per stage, with the
// carry registered between stages and a single global stall driven from the output.
module pipelined_rca_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
  localparam int NSTG       = WIDTH / SLICE_SAFE;

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE_SAFE) != 0)) begin : g_bad_params
    $error("pipelined_rca_addsub: WIDTH (%0d) must be a non-zero multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // The whole pipe moves together; a held result freezes every stage behind it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | c_in;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // Operand bits entering this stage: the current slice plus everything above it.
    localparam int RIN = WIDTH - k * SLICE;
    localparam int LO  = (k + 1) * SLICE;

    logic [RIN-1:0] a_src;
    logic [RIN-1:0] b_src;
    logic           cy_src;
    logic           v_src;
    logic [LO-1:0]  sum_d;
    logic [SLICE:0] slice_add;

    logic           vld_q;
    logic           cy_q;
    logic [LO-1:0]  sum_q;

    assign slice_add = {1'b0, a_src[SLICE-1:0]} + {1'b0, b_src[SLICE-1:0]}
                     + {{SLICE{1'b0}}, cy_src};

    if (k == 0) begin : g_head
      assign a_src  = a;
      assign b_src  = b_eff;
      assign cy_src = cin_eff;
      assign v_src  = in_valid;
      assign sum_d  = slice_add[SLICE-1:0];
    end else begin : g_head
      assign a_src  = g_stg[k-1].g_ops.a_q;
      assign b_src  = g_stg[k-1].g_ops.b_q;
      assign cy_src = g_stg[k-1].cy_q;
      assign v_src  = g_stg[k-1].vld_q;
      assign sum_d  = {slice_add[SLICE-1:0], g_stg[k-1].sum_q};
    end

    // NOTE: state uses non-blocking assignments and the async reset clears data as
    // well as valid bits, so a flushed pipe never shows a stale sum.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        vld_q <= v_src;
        cy_q  <= slice_add[SLICE];
        sum_q <= sum_d;
      end
    end

    if (k < NSTG - 1) begin : g_ops
      // Unresolved upper operand bits, right-aligned so the next stage reads bits [SLICE-1:0].
      logic [RIN-SLICE-1:0] a_q;
      logic [RIN-SLICE-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_src[RIN-1:SLICE];
          b_q <= b_src[RIN-1:SLICE];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // The top slice carries both operand sign bits, so overflow is settled here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (a_src[SLICE-1] == b_src[SLICE-1]) && (slice_add[SLICE-1] != a_src[SLICE-1]);
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].vld_q;
  assign sum       = g_stg[NSTG-1].sum_q;
  assign c_out     = g_stg[NSTG-1].cy_q;
  assign overflow  = g_stg[NSTG-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Bench for pipelined_rca_addsub: directed vectors on a 16/4 instance checked against an
// arithmetic scoreboard, plus literal checks on 8/8 and 32/8 instances.
module tb_pipelined_rca_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, overflow;
  logic [15:0] a, b, sum;

  logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;

  logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, s32;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_rca_addsub #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .overflow(overflow));

  pipelined_rca_addsub #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .c_out(co8), .overflow(of8));

  pipelined_rca_addsub #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .c_in(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .c_out(co32), .overflow(of32));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden result {c_out, overflow, sum} from plain unsigned and signed arithmetic.
  function automatic logic [17:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                        input logic fcin, input logic fsub);
    longint ua, ub, sa, sb, r, full;
    logic [15:0] s;
    logic co, ov;
    ua = longint'(fa);
    ub = longint'(fb);
    sa = fa[15] ? ua - 65536 : ua;
    sb = fb[15] ? ub - 65536 : ub;
    if (fsub) begin
      s  = 16'(ua - ub);
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      full = ua + ub + longint'(fcin);
      s  = 16'(full);
      co = (full > 65535);
      r  = sa + sb + longint'(fcin);
    end
    ov = (r > 32767) || (r < -32768);
    return {co, ov, s};
  endfunction

  // Scoreboard: every cycle out of reset, check the ready rule and any presented result.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          check("result", 64'({c_out, overflow, sum}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
  end

  task automatic run_single(input string name, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tcin, input logic tsub, input logic [15:0] es,
                            input logic eco, input logic eov);
    int lat;
    a = ta; b = tb; c_in = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(4));
    check({name, "_sum"}, 64'(sum), 64'(es));
    check({name, "_cout"}, 64'(c_out), 64'(eco));
    check({name, "_ovf"}, 64'(overflow), 64'(eov));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, cyc, stalls, n0, lat;
    logic acc;
    logic [3:0] pat;
    logic [7:0] hist;

    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(c_out), 64'(0));
    check("reset_ovf", 64'(overflow), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Model pins
    check("pin_model_add", 64'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 16'h8000}));
    check("pin_model_sub", 64'(model(16'h0003, 16'h0005, 1'b1, 1'b1)), 64'({1'b0, 1'b0, 16'hFFFE}));

    // Directed add / subtract
    run_single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_single("sub_neg",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Back-to-back stream with a three-cycle output stall
    n0 = n_out; i = 0; cyc = 0; stalls = 0;
    while (i < 8 && cyc < 60) begin
      a = 16'(i * 16'h1111); b = 16'h0F0F; sub = i[0]; c_in = 1'b0; in_valid = 1'b1;
      out_ready = !(cyc >= 5 && cyc < 8);
      @(negedge clk);
      acc = in_ready;
      if (out_valid && !out_ready) stalls++;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    #1;
    check("stream_accepted", 64'(i), 64'(8));
    check("stream_stall_cycles", 64'(stalls), 64'(3));
    check("stream_drained", 64'(exp_q.size()), 64'(0));
    check("stream_count", 64'(n_out - n0), 64'(8));

    // Bubbles propagate unchanged
    pat = 4'b0101;
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 4) ? pat[t] : 1'b0;
      a = 16'(16'h1000 + t); b = 16'h0234; sub = 1'b0; c_in = t[0];
      @(negedge clk);
      hist[t] = out_valid;
      @(posedge clk); #1;
    end
    check("bubble_pattern", 64'(hist), 64'({pat, 4'b0000}));

    // Asynchronous flush mid-stream
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1; a = 16'(16'h1234 + t); b = 16'h1111; sub = 1'b0; c_in = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_sum", 64'(sum), 64'(0));
    check("flush_cout", 64'(c_out), 64'(0));
    check("flush_ovf", 64'(overflow), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check("no_stale_out", 64'(out_valid), 64'(0));
      check("ready_after_reset", 64'(in_ready), 64'(1));
    end
    @(posedge clk); #1;

    // Single-stage 8/8 configuration: latency 1
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    check("w8_valid", 64'(ov8), 64'(1));
    check("w8_sum", 64'(s8), 64'(8'h01));
    check("w8_cout", 64'(co8), 64'(1));
    check("w8_ovf", 64'(of8), 64'(1));
    @(negedge clk);
    check("w8_valid_once", 64'(ov8), 64'(0));
    @(posedge clk); #1;

    // 32/8 configuration: latency 4
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; sub32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ov32) begin
        lat = k;
        break;
      end
    end
    check("w32_latency", 64'(lat), 64'(4));
    check("w32_sum", 64'(s32), 64'(0));
    check("w32_cout", 64'(co32), 64'(1));
    check("w32_ovf", 64'(of32), 64'(0));

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_addsub.md
Name: pipelined_rca_addsub

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 16-bit, 4-bit-slice ripple adder.
- WIDTH is split into SLICE-bit chunks; one chunk is resolved per pipeline stage.
- The carry is registered between stages, so the clock period is set by one slice, not the full word.
- Streaming valid/ready handshake in and out. Used as the datapath adder in the Lab ALU blocks.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE and ≥ SLICE.
SLICE, 4, bits resolved per pipeline stage.
NSTG, WIDTH/SLICE (derived localparam, not overridable), number of pipeline stages = latency in cycles.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and mode valid this cycle.
in_ready  output  1  block can accept an operation this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry in; used for add only.
sub  input  1  0 = A+B+c_in, 1 = A−B.
out_valid  output  1  result outputs valid.
out_ready  input  1  downstream accepts result this cycle.
sum  output  WIDTH  result.
c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, async): all stage valid bits, sum, c_out, overflow and out_valid clear to 0 immediately. All stage data registers also clear to 0. in_ready = 1 after reset.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : c_in; c_in is ignored when sub = 1.
- Pipeline:
  - Stage k (k = 0..NSTG−1) adds slice k of a and b_eff plus the registered carry from stage k−1 (cin_eff for k = 0).
  - Each stage registers:
    - completed low slices of sum
    - carry
    - remaining upper a/b_eff bits
    - a[WIDTH−1] and b_eff[WIDTH−1] for overflow
    - a valid bit
- Latency: an operation accepted at edge N presents out_valid = 1 with its result after edge N+NSTG−1. A 16/4 configuration shows the result during the 4th cycle after the accept cycle.
- Global stall:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance = 0, every stage holds its data and valid bit.
  - Bubbles are not collapsed while stalled.
- Accept occurs when in_valid && in_ready. When in_valid = 0 and the pipe advances, a bubble (valid = 0) enters stage 0.
- Output registers hold their values while out_valid && !out_ready.
- Throughput: one operation per cycle when out_ready stays high. Results leave in order; no loss or duplication.
- Result rules:
  - c_out = carry from the MSB slice.
  - overflow = (a_msb == b_eff_msb) && (sum[WIDTH−1] != a_msb).
  - Arithmetic is modulo 2^WIDTH.
- Boundaries:
  - NSTG = 1 (SLICE == WIDTH): single registered stage, latency 1.
  - Simultaneous accept and output handshake in the same cycle is legal; both complete.
  - rst_n asserted mid-operation flushes every in-flight operation; nothing emerges after release.
  - Illegal parameters (WIDTH % SLICE != 0, or SLICE > WIDTH) stop elaboration with an error; no silent truncation.
- Stage data and valid bits are registered. The only combinational paths are in_ready from out_valid/out_ready and the stage-0 slice add.

Test Plan:
1. Reset: drive rst_n low mid-stream with in_valid high → out_valid, sum, c_out, overflow go to 0 without a clock edge. After release, in_ready = 1 and no stale result appears in the next 8 cycles.
2. WIDTH=16, SLICE=4, add: a=0xFFFF, b=0x0001, c_in=0 accepted at cycle 0 → out_valid high on cycle 4 with sum=0x0000, c_out=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, overflow=1.
3. Subtract: sub=1, a=0x8000, b=0x0001, c_in=1 → sum=0x7FFF, c_out=1, overflow=1 (c_in ignored). Then a=0x0003, b=0x0005 → sum=0xFFFE, c_out=0, overflow=0.
4. Stream 8 back-to-back ops (a=i×0x1111, b=0x0F0F, alternating sub), out_ready low for 3 cycles mid-stream → in_ready low exactly while out_valid && !out_ready. All 8 results arrive in order, match the golden model, with none dropped or repeated.
5. Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 → out_valid pattern 1,0,1,0 delayed by NSTG cycles, with the correct sums.
6. WIDTH=8, SLICE=8: a=0x80, b=0x80, c_in=1 → after 1 cycle sum=0x01, c_out=1, overflow=1. WIDTH=32, SLICE=8: 0xFFFFFFFF+0+1 → sum=0, c_out=1, latency 4.
